seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of seven-segment digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clk cycles each digit is driven (legal >=2).
REQ-003 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (legal >=2).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cs  input  1  register-file select from the MMIO decoder.
REQ-007 wr  input  1  write strobe; a write occurs on each clk edge with cs=1 and wr=1.
REQ-008 addr  input  2  register index: 0 VAL_LO, 1 VAL_HI, 2 CTRL, 3 STATUS (read-only).
REQ-009 wdata  input  16  write data.
REQ-010 rdata  output  16  combinational read data for addr: VAL_LO, VAL_HI, CTRL, {15'b0,busy}; 0 when cs=0.
REQ-011 an  output  DIGITS  registered active-low digit enables.
REQ-012 seg  output  8  registered active-low segments, seg[0]=a..seg[6]=g, seg[7]=dp.
REQ-013 busy  output  1  registered; high while a decimal conversion runs.

Function
REQ-014 CTRL bits: [0] mode (0 hex, 1 decimal), [1] blink enable, [2] leading-zero suppress, [15:8] digit enable mask (bit i enables digit i; bits >= DIGITS ignored); other bits read 0.
REQ-015 Value register is 32 bits, {VAL_HI,VAL_LO}; writes to addr 3 are ignored.
REQ-016 Hex mode: digit i shows value nibble i; display digits update the cycle after the write.
REQ-017 Decimal mode: a write to VAL_LO, VAL_HI or CTRL with mode=1 starts a shift-and-add-3 conversion of the full 32-bit value, one bit per cycle, 32 cycles; busy rises the cycle after the write and falls after the 32nd shift cycle.
REQ-018 Decimal results (10 BCD digits) are committed atomically to the display when busy falls; until then the previous digits remain displayed.
REQ-019 Decimal overflow: if any BCD digit at index >= DIGITS is nonzero, all digits show '-' (seg 8'hBF).
REQ-020 A write while busy=1 aborts the running conversion and restarts it from the new value; busy stays high continuously.
REQ-021 Writing mode=0 while busy=1 aborts the conversion, drops busy the next cycle, and shows hex immediately.
REQ-022 Scan counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and the digit index increments, wrapping DIGITS-1 -> 0.
REQ-023 For the current index k: an = ~(1<<k) if mask bit k=1 and not blanked, else all ones; seg = glyph of digit k.
REQ-024 Glyphs 0-F active-low: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E; dp always off.
REQ-025 Leading-zero suppress: digits above the highest nonzero displayed digit are blanked (an bit high); digit 0 is never blanked; not applied to the overflow pattern.
REQ-026 Blink: a blink counter toggles a phase every BLINK_DIV cycles; with blink enabled and phase=off, an is all ones; disabling blink shows digits the next cycle.
REQ-027 Outputs change only on clk edges; no combinational path from bus inputs to an/seg.

Reset
REQ-028 On rst=1: value=0, CTRL=16'hFF00, scan counter, digit index, blink counter and phase=on cleared, conversion aborted, busy=0, an=all ones, seg=8'hFF.
REQ-029 Reset mid-conversion discards the partial result; the display shows hex 0 after reset.
REQ-030 First digit drive (index 0, "0") occurs the cycle after rst deasserts.

Verification (DIGITS=8, SCAN_DIV=4, BLINK_DIV=64)
REQ-031 Write VAL_LO=16'h1234, VAL_HI=16'hABCD, hex mode -> over 32 cycles an steps FE,FD,...,7F every 4 cycles with seg 99,B0,A4,F9,A1,C6,83,88.
REQ-032 VAL_LO=16'h4E20 (20000), CTRL=16'hFF05 -> busy high 32 cycles; then digits 0-4 show 0,0,0,0,2 and an bits 5-7 stay high.
REQ-033 Decimal with VAL_HI=16'h05F5, VAL_LO=16'hE100 (100000000) -> all eight digits show BF after busy falls.
REQ-034 Write VAL_LO=5 in decimal mode, rewrite VAL_LO=7 ten cycles later -> busy continuous, digit 0 never shows 5, shows F8 after completion.
REQ-035 CTRL=16'h0F02 -> an bits 4-7 always high; an all ones for 64-cycle windows alternating with 64-cycle scanning.
REQ-036 Assert rst at conversion cycle 15 -> busy=0, an=FF, seg=FF same edge; digit 0 shows C0 after release.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// MMIO register-file bus for the seven-segment scan controller.
// The decoder side drives select/strobe/address/data; the controller returns read data.
interface seg_scan_ctrl_if;
  logic        cs;
  logic        wr;
  logic [1:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cs, output wr, output addr, output wdata, input rdata);
  modport slave  (input cs, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Seven-segment multiplexed display controller.
// Shows a 32-bit value as hex nibbles or, after a shift-and-add-3 conversion,
// as decimal digits, with per-digit enable mask, leading-zero blanking and blink.
module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_ctrl_if.slave    bus,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  output logic              busy
);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int IDX_W   = $clog2(DIGITS);

  // Active-low segment pattern for one hex digit; dp stays off.
  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      4'hF: glyph = 8'h8E;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
  function automatic logic [39:0] bcd_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = 40'h0;
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  logic [31:0]        val_r;
  logic               mode_r, blink_en_r, lzs_r;
  logic [7:0]         mask_r;
  logic [31:0]        bin_r;
  logic [39:0]        bcd_r;
  logic [4:0]         bit_cnt_r;
  logic               busy_r;
  logic [31:0]        disp_r;
  logic               ovf_r;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               phase_r;
  logic [DIGITS-1:0]  an_r;
  logic [7:0]         seg_r;

  logic [31:0]        val_nxt_s;
  logic               mode_nxt_s, blink_nxt_s, lzs_nxt_s;
  logic [7:0]         mask_nxt_s;
  logic               reg_wr_s;
  logic [15:0]        rdata_s;
  logic [39:0]        bcd_adj_s, bcd_shift_s;
  logic               bcd_ovf_s, commit_s;
  logic [3:0]         cur_dig_s;
  logic [IDX_W-1:0]   hi_dig_s;
  logic               blank_s;
  logic [DIGITS-1:0]  an_nxt_s;
  logic [7:0]         seg_nxt_s;

  // Read mux; STATUS reports busy, unimplemented CTRL bits read as zero.
  always_comb begin
    rdata_s = 16'h0000;
    if (bus.cs) begin
      case (bus.addr)
        2'd0:    rdata_s = val_r[15:0];
        2'd1:    rdata_s = val_r[31:16];
        2'd2:    rdata_s = {mask_r, 5'b00000, lzs_r, blink_en_r, mode_r};
        2'd3:    rdata_s = {15'h0000, busy_r};
        default: rdata_s = 16'h0000;
      endcase
    end else begin
      rdata_s = 16'h0000;
    end
  end

  assign bus.rdata = rdata_s;

  // Next register contents after a bus write; STATUS writes change nothing.
  always_comb begin
    val_nxt_s   = val_r;
    mode_nxt_s  = mode_r;
    blink_nxt_s = blink_en_r;
    lzs_nxt_s   = lzs_r;
    mask_nxt_s  = mask_r;
    reg_wr_s    = 1'b0;
    if (bus.cs && bus.wr) begin
      case (bus.addr)
        2'd0: begin
          val_nxt_s[15:0] = bus.wdata;
          reg_wr_s        = 1'b1;
        end
        2'd1: begin
          val_nxt_s[31:16] = bus.wdata;
          reg_wr_s         = 1'b1;
        end
        2'd2: begin
          mode_nxt_s  = bus.wdata[0];
          blink_nxt_s = bus.wdata[1];
          lzs_nxt_s   = bus.wdata[2];
          mask_nxt_s  = bus.wdata[15:8];
          reg_wr_s    = 1'b1;
        end
        default: reg_wr_s = 1'b0;
      endcase
    end else begin
      reg_wr_s = 1'b0;
    end
  end

  // One double-dabble step plus overflow detection on the digits we cannot show.
  always_comb begin
    bcd_adj_s   = bcd_adjust(bcd_r);
    bcd_shift_s = {bcd_adj_s[38:0], bin_r[31]};
    bcd_ovf_s   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bcd_ovf_s = bcd_ovf_s | ((i >= DIGITS) && (bcd_shift_s[4*i +: 4] != 4'h0));
    end
    commit_s = busy_r && mode_nxt_s && !reg_wr_s && (bit_cnt_r == 5'd31);
  end

  // Registers, conversion sequencing and the atomically-updated display digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r      <= 32'h0000_0000;
      mode_r     <= 1'b0;
      blink_en_r <= 1'b0;
      lzs_r      <= 1'b0;
      mask_r     <= 8'hFF;
      bin_r      <= 32'h0000_0000;
      bcd_r      <= 40'h0;
      bit_cnt_r  <= 5'd0;
      busy_r     <= 1'b0;
      disp_r     <= 32'h0000_0000;
      ovf_r      <= 1'b0;
    end else begin
      val_r      <= val_nxt_s;
      mode_r     <= mode_nxt_s;
      blink_en_r <= blink_nxt_s;
      lzs_r      <= lzs_nxt_s;
      mask_r     <= mask_nxt_s;
      if (reg_wr_s && mode_nxt_s) begin
        // Any value/CTRL write in decimal mode (re)starts from the new value.
        busy_r    <= 1'b1;
        bin_r     <= val_nxt_s;
        bcd_r     <= 40'h0;
        bit_cnt_r <= 5'd0;
      end else if (busy_r && mode_nxt_s) begin
        bin_r     <= {bin_r[30:0], 1'b0};
        bcd_r     <= bcd_shift_s;
        bit_cnt_r <= bit_cnt_r + 5'd1;
        busy_r    <= (bit_cnt_r != 5'd31);
      end else begin
        busy_r <= 1'b0;
      end
      if (!mode_nxt_s) begin
        disp_r <= val_nxt_s;
        ovf_r  <= 1'b0;
      end else if (commit_s) begin
        disp_r <= bcd_shift_s[31:0];
        ovf_r  <= bcd_ovf_s;
      end else begin
        disp_r <= disp_r;
        ovf_r  <= ovf_r;
      end
    end
  end

  // Pattern for the digit currently selected by the scan index.
  always_comb begin
    cur_dig_s = 4'h0;
    hi_dig_s  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      hi_dig_s  = (disp_r[4*i +: 4] != 4'h0) ? IDX_W'(i) : hi_dig_s;
      cur_dig_s = (idx_r == IDX_W'(i)) ? disp_r[4*i +: 4] : cur_dig_s;
    end
    blank_s  = lzs_r && !ovf_r && (idx_r > hi_dig_s);
    an_nxt_s = '1;
    if (mask_r[idx_r] && !blank_s && (phase_r || !blink_en_r)) begin
      an_nxt_s[idx_r] = 1'b0;
    end else begin
      an_nxt_s = '1;
    end
    seg_nxt_s = ovf_r ? 8'hBF : glyph(cur_dig_s);
  end

  // Scan and blink timebases plus the registered digit/segment drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_r  <= '0;
      idx_r       <= '0;
      blink_cnt_r <= '0;
      phase_r     <= 1'b1;
      an_r        <= '1;
      seg_r       <= 8'hFF;
    end else begin
      if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt_r <= '0;
        idx_r      <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end
      if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  assign an   = an_r;
  assign seg  = seg_r;
  assign busy = busy_r;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus pushes expected per-digit drives,
// a monitor pops them when the scan reaches that digit.
module tb_seg_scan_ctrl;
  localparam int DIGITS    = 8;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 64;
  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        busy;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc;

  typedef struct {
    int         k;
    logic [7:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_k;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .an   (an),
    .seg  (seg),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Edges since reset release: output after edge n belongs to scan slot (n-1)/SCAN_DIV.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: when the scan reaches the digit at the head of the queue, compare it.
  always @(negedge clk) begin
    if (!rst && cyc >= 1 && sb_q.size() > 0) begin
      mon_k = ((cyc - 1) / SCAN_DIV) % DIGITS;
      if (sb_q[0].k == mon_k) begin
        mon_e = sb_q.pop_front();
        check($sformatf("an_digit%0d", mon_k), {24'h0, an}, {24'h0, mon_e.an});
        check($sformatf("seg_digit%0d", mon_k), {24'h0, seg}, {24'h0, mon_e.seg});
      end
    end
  end

  // Reference model: what each digit should show for value v and CTRL c (blink off).
  task automatic push_expect(input logic [31:0] v, input logic [15:0] c);
    int          d [10];
    logic [31:0] t;
    logic        ovf;
    int          hi;
    exp_t        e;
    t = v;
    for (int i = 0; i < 10; i++) begin
      if (c[0]) begin
        d[i] = int'(t % 32'd10);
        t    = t / 32'd10;
      end else begin
        d[i] = (i < 8) ? int'((v >> (4 * i)) & 32'hF) : 0;
      end
    end
    ovf = c[0] && (v >= 32'd100000000);
    hi = 0;
    for (int i = 0; i < DIGITS; i++) if (d[i] != 0) hi = i;
    for (int k = 0; k < DIGITS; k++) begin
      e.k   = k;
      e.an  = (c[8 + k] && !(c[2] && !ovf && k > hi)) ? ~(8'd1 << k) : 8'hFF;
      e.seg = ovf ? 8'hBF : GLYPH[d[k]];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [1:0] a, input logic [15:0] req);
    bus.cs = 1'b1; bus.wr = 1'b0; bus.addr = a;
    #1;
    check(name, {16'h0, bus.rdata}, {16'h0, req});
    bus.cs = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_txn(input logic [31:0] v, input logic [15:0] c);
    int n;
    bus_write(2'd0, v[15:0]);
    bus_write(2'd1, v[31:16]);
    bus_write(2'd2, c);
    busy_len(n);
    check("busy_cycles", n, c[0] ? 32 : 0);
    repeat (2) @(negedge clk);
    bus_read("rd_val_lo", 2'd0, v[15:0]);
    bus_read("rd_val_hi", 2'd1, v[31:16]);
    bus_read("rd_ctrl", 2'd2, c & 16'hFF07);
    bus_read("rd_status", 2'd3, 16'h0000);
    push_expect(v, c);
    wait_drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, bad, k, sel;
    logic        dropped, on;
    logic [31:0] v;
    logic [15:0] c;

    rst = 1'b1;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.wdata = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_an", {24'h0, an}, 32'hFF);
    check("reset_seg", {24'h0, seg}, 32'hFF);
    check("reset_busy", {31'h0, busy}, 32'h0);
    bus_read("reset_ctrl", 2'd2, 16'hFF00);
    bus_read("reset_val_lo", 2'd0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("first_drive_an", {24'h0, an}, 32'hFE);
    check("first_drive_seg", {24'h0, seg}, 32'hC0);
    push_expect(32'h0, 16'hFF00);
    wait_drain();

    // Read data is zero without chip select.
    bus.cs = 1'b0; bus.addr = 2'd2;
    #1;
    check("rd_no_cs", {16'h0, bus.rdata}, 32'h0);

    // Hex scan, decimal with leading-zero suppress, decimal overflow.
    run_txn(32'hABCD_1234, 16'hFF00);
    run_txn(32'h0000_4E20, 16'hFF05);
    run_txn(32'h05F5_E100, 16'hFF01);
    run_txn(32'h05F5_E0FF, 16'hFF01);

    // STATUS writes are ignored.
    bus_write(2'd3, 16'hFFFF);
    bus_read("status_write_ignored_lo", 2'd0, 16'hE0FF);
    bus_read("status_write_ignored_ctrl", 2'd2, 16'hFF01);

    // Restart while busy: 5 then 7 ten cycles later.
    run_txn(32'h0000_0000, 16'hFF01);
    bus_write(2'd0, 16'h0005);
    bad = 0;
    dropped = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b1) dropped = 1'b1;
      if (an[0] === 1'b0 && seg === 8'h92) bad++;
      n++;
      if (i < 9) @(negedge clk);
    end
    bus_write(2'd0, 16'h0007);
    while (busy === 1'b1 && n < 200) begin
      if (an[0] === 1'b0 && seg === 8'h92) bad++;
      n++;
      @(negedge clk);
    end
    check("restart_busy_continuous", {31'h0, dropped}, 32'h0);
    check("restart_busy_cycles", n, 42);
    repeat (40) begin
      if (an[0] === 1'b0 && seg === 8'h92) bad++;
      @(negedge clk);
    end
    check("restart_never_shows_5", bad, 0);
    push_expect(32'h7, 16'hFF01);
    wait_drain();

    // Abort by switching to hex while busy.
    bus_write(2'd0, 16'h0321);
    @(negedge clk);
    bus_write(2'd2, 16'hFF00);
    check("abort_busy_low", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    push_expect(32'h0000_0321, 16'hFF00);
    wait_drain();

    // Blink with digits 4-7 masked off.
    bus_write(2'd0, 16'h3210);
    bus_write(2'd2, 16'h0F02);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4 * BLINK_DIV; i++) begin
      k  = ((cyc - 1) / SCAN_DIV) % DIGITS;
      on = (((cyc - 1) / BLINK_DIV) % 2) == 0;
      check("an_blink", {24'h0, an}, {24'h0, (on && k < 4) ? ~(8'd1 << k) : 8'hFF});
      @(negedge clk);
    end
    bus_write(2'd2, 16'hFF00);
    repeat (2) @(negedge clk);
    push_expect(32'h0000_3210, 16'hFF00);
    wait_drain();

    // Reset in the middle of a conversion.
    bus_write(2'd0, 16'h1234);
    bus_write(2'd1, 16'h0000);
    bus_write(2'd2, 16'hFF01);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midconv_reset_busy", {31'h0, busy}, 32'h0);
    check("midconv_reset_an", {24'h0, an}, 32'hFF);
    check("midconv_reset_seg", {24'h0, seg}, 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_an", {24'h0, an}, 32'hFE);
    check("after_reset_seg", {24'h0, seg}, 32'hC0);
    bus_read("after_reset_val", 2'd0, 16'h0000);
    bus_read("after_reset_ctrl", 2'd2, 16'hFF00);
    push_expect(32'h0, 16'hFF00);
    wait_drain();

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(0, 99999999);
        default: v = $urandom & 32'h000F_00F0;
      endcase
      c = {8'($urandom), 5'($urandom), 1'($urandom), 1'b0, 1'($urandom)};
      run_txn(v, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
